// File: rtl/param_loader.sv
// Parameter loader: takes weight and bias bytes from the host stream into on-chip
// memories and serves the inference engine's read ports with registered data.
module param_loader #(
  parameter int unsigned NUM_CLASSES   = 10,
  parameter int unsigned NUM_PIXELS    = 784,
  parameter int unsigned WEIGHT_ADDR_W = 13,
  parameter int unsigned BIAS_ADDR_W   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     load_start,
  input  logic                     inference_busy,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WEIGHT_ADDR_W-1:0] weight_addr,
  output logic [7:0]               weight_data,
  input  logic [BIAS_ADDR_W-1:0]   bias_addr,
  output logic [31:0]              bias_data,
  output logic                     weights_ready,
  output logic                     load_active,
  output logic [13:0]              byte_count
);

  localparam int unsigned W_TOTAL = NUM_CLASSES * NUM_PIXELS;

  typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_B, READY} state_e;

  state_e                 state_q, state_d;
  logic [13:0]            byte_count_q, byte_count_d;
  logic [23:0]            bias_sr_q, bias_sr_d;
  logic [1:0]             bias_sub_q, bias_sub_d;
  logic [BIAS_ADDR_W-1:0] bias_idx_q, bias_idx_d;
  logic                   weights_ready_q, weights_ready_d;
  logic [7:0]             weight_data_q, weight_data_d;
  logic [31:0]            bias_data_q, bias_data_d;

  logic [7:0]  wmem [W_TOTAL];
  logic [31:0] bmem [NUM_CLASSES];

  logic        start;
  logic        xfer;
  logic        w_we;
  logic        b_we;
  logic [31:0] b_wdata;

  assign in_ready      = (state_q == LOAD_W) || (state_q == LOAD_B);
  assign load_active   = in_ready;
  assign start         = load_start && !inference_busy;
  assign xfer          = in_valid && in_ready;
  assign weights_ready = weights_ready_q;
  assign byte_count    = byte_count_q;
  assign weight_data   = weight_data_q;
  assign bias_data     = bias_data_q;

  always_comb begin
    state_d         = state_q;
    byte_count_d    = byte_count_q;
    bias_sr_d       = bias_sr_q;
    bias_sub_d      = bias_sub_q;
    bias_idx_d      = bias_idx_q;
    weights_ready_d = weights_ready_q;
    w_we            = 1'b0;
    b_we            = 1'b0;
    b_wdata         = {in_data, bias_sr_q};

    // A restart wins over a byte presented in the same cycle; that byte is dropped.
    if (start) begin
      state_d         = LOAD_W;
      byte_count_d    = '0;
      bias_sr_d       = '0;
      bias_sub_d      = '0;
      bias_idx_d      = '0;
      weights_ready_d = 1'b0;
    end else if (xfer) begin
      byte_count_d = byte_count_q + 14'd1;
      if (state_q == LOAD_W) begin
        w_we = 1'b1;
        if (byte_count_q == 14'(W_TOTAL - 1)) begin
          state_d = LOAD_B;
        end
      end else begin
        bias_sr_d  = {in_data, bias_sr_q[23:8]};
        bias_sub_d = bias_sub_q + 2'd1;
        if (bias_sub_q == 2'd3) begin
          b_we       = 1'b1;
          bias_idx_d = bias_idx_q + 1'b1;
          if (bias_idx_q == BIAS_ADDR_W'(NUM_CLASSES - 1)) begin
            state_d         = READY;
            weights_ready_d = 1'b1;
          end
        end
      end
    end

    weight_data_d = (32'(weight_addr) < W_TOTAL) ? wmem[weight_addr] : '0;
    bias_data_d   = (32'(bias_addr) < NUM_CLASSES) ? bmem[bias_addr] : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      byte_count_q    <= '0;
      bias_sr_q       <= '0;
      bias_sub_q      <= '0;
      bias_idx_q      <= '0;
      weights_ready_q <= 1'b0;
      weight_data_q   <= '0;
      bias_data_q     <= '0;
    end else begin
      state_q         <= state_d;
      byte_count_q    <= byte_count_d;
      bias_sr_q       <= bias_sr_d;
      bias_sub_q      <= bias_sub_d;
      bias_idx_q      <= bias_idx_d;
      weights_ready_q <= weights_ready_d;
      weight_data_q   <= weight_data_d;
      bias_data_q     <= bias_data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_we) wmem[byte_count_q[WEIGHT_ADDR_W-1:0]] <= in_data;
    if (b_we) bmem[bias_idx_q] <= b_wdata;
  end

endmodule

// File: doc/param_loader.md
Name: param_loader

Overview:
- Writer/responder end of the inference memory interface.
- Accepts a byte stream from the host link (UART RX side) and stores NUM_CLASSES*NUM_PIXELS weight bytes and NUM_CLASSES 32-bit biases.
- Serves the inference engine's weight_addr/bias_addr read ports with 1-cycle registered data.
- Raises weights_ready once a complete parameter set has been received.

Parameters:
- NUM_CLASSES, 10, number of output classes / biases.
- NUM_PIXELS, 784, weights per class.
- WEIGHT_ADDR_W, 13, weight address width; must satisfy 2^WEIGHT_ADDR_W >= NUM_CLASSES*NUM_PIXELS.
- BIAS_ADDR_W, 4, bias address width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- load_start  in  1  single-cycle pulse; begins a new parameter load.
- inference_busy  in  1  busy flag from the inference engine.
- in_data  in  8  stream byte.
- in_valid  in  1  stream byte valid.
- in_ready  out  1  loader accepts a byte this cycle.
- weight_addr  in  WEIGHT_ADDR_W  read address from the inference engine.
- weight_data  out  8  registered weight byte.
- bias_addr  in  BIAS_ADDR_W  read address from the inference engine.
- bias_data  out  32  registered bias word.
- weights_ready  out  1  complete parameter set stored.
- load_active  out  1  high while in LOAD_W or LOAD_B.
- byte_count  out  14  bytes accepted in the current load.

Behaviour:
- Reset values (asynchronous, rst_n=0): state IDLE; in_ready=0; weights_ready=0; load_active=0; byte_count=0; weight_data=0; bias_data=0. Memory contents are not cleared.
- States: IDLE, LOAD_W, LOAD_B, READY.
- IDLE/READY -> LOAD_W on load_start=1 with inference_busy=0.
  - On that transition: clear weights_ready, byte_count and the bias assembly register.
  - load_start while inference_busy=1 is ignored; state, weights_ready and memory are unchanged.
- Handshake: a byte transfers on a cycle with in_valid && in_ready. in_ready is combinational, equal to (state==LOAD_W || state==LOAD_B). No skid buffer.
- LOAD_W:
  - Each transfer writes in_data to weight memory at address byte_count, then byte_count increments.
  - Byte order is class-major: address = class*NUM_PIXELS + pixel.
  - After the transfer at address NUM_CLASSES*NUM_PIXELS-1 (7839), go to LOAD_B on the next cycle.
- LOAD_B:
  - Each bias is 4 bytes, LSB first, assembled in a shift register.
  - On the 4th byte, the full word is written to bias memory at index (byte_count-7840)/4.
  - After the 4th byte of bias NUM_CLASSES-1 (total 7880 bytes), go to READY and set weights_ready=1 on the next cycle.
- READY: weights_ready held at 1; in_ready=0. Extra stream bytes are not accepted and stay pending upstream.
- load_start during LOAD_W/LOAD_B restarts the load:
  - byte_count returns to 0 and the partial bias is discarded.
  - weights_ready stays 0.
  - Already-written memory locations keep their old values until overwritten.
- Read ports: weight_data <= mem[weight_addr] and bias_data <= bmem[bias_addr], registered, 1-cycle latency, every cycle regardless of state.
  - weight_addr >= 7840 returns 8'd0.
  - bias_addr >= NUM_CLASSES returns 32'd0.
- Read/write collision on the same address in the same cycle returns the old data (read-first).
- Reset mid-load: immediate return to IDLE with weights_ready=0; a new load_start is required.

Test Plan:
- Reset, then pulse load_start, stream 7840 bytes of 0x00 and 10 biases of N*1000 (N=0..9, LSB first) -> weights_ready rises 1 cycle after byte 7880. bias_addr=9 gives bias_data=9000 one cycle later; weight_addr=100 gives 0.
- Weight byte k = k[7:0] -> weight_addr=7839 returns 0x9F after 1 cycle; weight_addr=8000 returns 0.
- in_valid toggled randomly 50% during the load -> same memory contents; byte_count=7880 at the end; no byte is written while in_ready=0.
- load_start asserted at byte 5000, then a full reload with weight value 0x11 -> weights_ready low until the second load completes; every weight reads 0x11.
- load_start with inference_busy=1 in READY -> state stays READY, weights_ready=1, in_ready=0.
- rst_n pulsed low at byte 7850 (mid-bias) -> all outputs return to reset values asynchronously; in_ready=0 until the next load_start.
